// File: rtl/mii_phy_tx_ifg_if.sv
// mii_phy_tx_ifg_if
//   MAC-to-PHY transmit interface for MII/GMII-style links. MAC words are
//   registered, queued in a small elastic FIFO and replayed toward the PHY.
//   Inter-frame gaps shorter than IFG_MIN idle cycles are stretched. The
//   block also generates the synchronised TX-domain reset for the MAC.
//   Optional feature macro: MII_PHY_TX_IFG_IF_STATS_EN enables the
//   frame_count / drop_count statistics counters (tied to zero otherwise).
module mii_phy_tx_ifg_if #(
  parameter int DATA_WIDTH      = 4,
  parameter int RST_SYNC_STAGES = 4,
  parameter int FIFO_DEPTH      = 16,
  parameter int IFG_MIN         = 24,
  parameter int OUT_REG_STAGES  = 1
) (
  input  logic                  mac_mii_tx_clk,
  input  logic                  rst,
  output logic                  mac_mii_tx_rst,
  input  logic [DATA_WIDTH-1:0] mac_mii_txd,
  input  logic                  mac_mii_tx_en,
  input  logic                  mac_mii_tx_er,
  output logic [DATA_WIDTH-1:0] phy_mii_txd,
  output logic                  phy_mii_tx_en,
  output logic                  phy_mii_tx_er,
  output logic                  ifg_stretch,
  output logic                  fifo_overflow,
  output logic [15:0]           frame_count,
  output logic [15:0]           drop_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = $clog2(IFG_MIN + 1);
  // FIFO word: {txd, tx_er, eof}; PHY word: {tx_en, tx_er, txd}
  localparam int FW = DATA_WIDTH + 2;
  localparam int PW = DATA_WIDTH + 2;
  localparam logic [GW-1:0] GAP_MAX = GW'(IFG_MIN);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // ---------------------------------------------------------------
  // Reset synchroniser: all-ones on rst, zeros shift in from the top
  // ---------------------------------------------------------------
  logic [RST_SYNC_STAGES-1:0] sync_q;
  logic                       hold;

  // shift register releasing the TX-domain reset
  always_ff @(posedge mac_mii_tx_clk or posedge rst) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {1'b0, sync_q[RST_SYNC_STAGES-1:1]};
  end

  assign mac_mii_tx_rst = sync_q[0];
  // everything below stays in its reset state while the MAC is in reset
  assign hold = sync_q[0];

  // ---------------------------------------------------------------
  // Input register
  // ---------------------------------------------------------------
  logic [DATA_WIDTH-1:0] in_d;
  logic                  in_en;
  logic                  in_er;

  // capture the MAC word once before it enters the FIFO
  always_ff @(posedge mac_mii_tx_clk or posedge rst) begin
    if (rst) begin
      in_d  <= '0;
      in_en <= 1'b0;
      in_er <= 1'b0;
    end else if (hold) begin
      in_d  <= '0;
      in_en <= 1'b0;
      in_er <= 1'b0;
    end else begin
      in_d  <= mac_mii_txd;
      in_en <= mac_mii_tx_en;
      in_er <= mac_mii_tx_er;
    end
  end

  // ---------------------------------------------------------------
  // Elastic FIFO
  // ---------------------------------------------------------------
  logic [FW-1:0]         mem [FIFO_DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  empty;
  logic                  full;
  logic [FW-1:0]         rd_word;
  logic [DATA_WIDTH-1:0] rd_d;
  logic                  rd_er;
  logic                  rd_eof;
  logic                  pop;
  logic                  wr_en;
  logic                  ovf_now;
  logic                  drop_q;
  logic                  ovf_q;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_word = mem[rd_ptr[AW-1:0]];
  assign rd_d    = rd_word[FW-1:2];
  assign rd_er   = rd_word[1];
  assign rd_eof  = rd_word[0];

  // write qualification: a pop in the same cycle frees the slot of a full FIFO
  always_comb begin
    wr_en   = 1'b0;
    ovf_now = 1'b0;
    if (in_en && !drop_q) begin
      if (full && !pop) ovf_now = 1'b1;
      else              wr_en   = 1'b1;
    end
  end

  // FIFO storage; eof marks the word after which the MAC dropped tx_en
  always_ff @(posedge mac_mii_tx_clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {in_d, in_er, ~mac_mii_tx_en};
  end

  // pointers, overflow pulse and rest-of-frame discard flag
  always_ff @(posedge mac_mii_tx_clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      drop_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (hold) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      drop_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      ovf_q <= ovf_now;
      if (!in_en)                        drop_q <= 1'b0;
      else if (ovf_now && mac_mii_tx_en) drop_q <= 1'b1;
    end
  end

  assign fifo_overflow = ovf_q;

  // ---------------------------------------------------------------
  // Gap-enforcing transmit FSM
  // ---------------------------------------------------------------
  state_t        state_q, state_nxt;
  logic [GW-1:0] gap_q, gap_nxt;
  logic [PW-1:0] fsm_word;
  logic          stretch;
  logic          frame_inc;
  logic          drop_inc;

  // state register; gap counter starts saturated so the first frame is not held
  always_ff @(posedge mac_mii_tx_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gap_q   <= GAP_MAX;
    end else if (hold) begin
      state_q <= IDLE;
      gap_q   <= GAP_MAX;
    end else begin
      state_q <= state_nxt;
      gap_q   <= gap_nxt;
    end
  end

  // next state, pop and the word presented to the output pipeline
  always_comb begin
    state_nxt = state_q;
    gap_nxt   = gap_q;
    pop       = 1'b0;
    fsm_word  = '0;
    stretch   = 1'b0;
    frame_inc = 1'b0;
    drop_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && (gap_q == GAP_MAX)) begin
          pop      = 1'b1;
          fsm_word = {1'b1, rd_er, rd_d};
          if (rd_eof) begin
            gap_nxt   = '0;
            frame_inc = 1'b1;
          end else begin
            state_nxt = SEND;
          end
        end else begin
          if (gap_q != GAP_MAX) gap_nxt = gap_q + 1'b1;
          stretch = !empty;
        end
      end
      SEND: begin
        if (!empty) begin
          pop      = 1'b1;
          fsm_word = {1'b1, rd_er, rd_d};
          if (rd_eof) begin
            state_nxt = IDLE;
            gap_nxt   = '0;
            frame_inc = 1'b1;
          end
        end else begin
          // data ran out mid-frame: poison the frame on the wire
          fsm_word  = {1'b1, 1'b1, {DATA_WIDTH{1'b0}}};
          state_nxt = IDLE;
          gap_nxt   = '0;
          drop_inc  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ifg_stretch = stretch;

  // ---------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------
`ifdef MII_PHY_TX_IFG_IF_STATS_EN
  logic [15:0] frame_q;
  logic [15:0] drop_cnt_q;

  // frame and truncation counters, wrapping at 16 bits
  always_ff @(posedge mac_mii_tx_clk or posedge rst) begin
    if (rst) begin
      frame_q    <= '0;
      drop_cnt_q <= '0;
    end else if (hold) begin
      frame_q    <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (frame_inc) frame_q    <= frame_q + 1'b1;
      if (drop_inc)  drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign frame_count = frame_q;
  assign drop_count  = drop_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = frame_inc ^ drop_inc;
  assign frame_count  = 16'd0;
  assign drop_count   = 16'd0;
`endif

  // ---------------------------------------------------------------
  // Output pipeline; the last stage is meant to sit in the I/O cell
  // ---------------------------------------------------------------
  logic [PW-1:0] pre_last;

  generate
    if (OUT_REG_STAGES > 1) begin : g_pipe
      logic [PW-1:0] pipe_q [OUT_REG_STAGES-1];

      // intermediate output stages
      always_ff @(posedge mac_mii_tx_clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < OUT_REG_STAGES - 1; i++) pipe_q[i] <= '0;
        end else if (hold) begin
          for (int i = 0; i < OUT_REG_STAGES - 1; i++) pipe_q[i] <= '0;
        end else begin
          pipe_q[0] <= fsm_word;
          for (int i = 1; i < OUT_REG_STAGES - 1; i++) pipe_q[i] <= pipe_q[i-1];
        end
      end

      assign pre_last = pipe_q[OUT_REG_STAGES-2];
    end else begin : g_nopipe
      assign pre_last = fsm_word;
    end
  endgenerate

  (* IOB = "TRUE" *) logic [PW-1:0] phy_q;

  // final PHY-facing register, cleared asynchronously so rst idles the pins at once
  always_ff @(posedge mac_mii_tx_clk or posedge rst) begin
    if (rst)       phy_q <= '0;
    else if (hold) phy_q <= '0;
    else           phy_q <= pre_last;
  end

  assign phy_mii_tx_en = phy_q[PW-1];
  assign phy_mii_tx_er = phy_q[PW-2];
  assign phy_mii_txd   = phy_q[DATA_WIDTH-1:0];

endmodule
